// File: rtl/countdown_timer_if.sv
// Control and status bundle for countdown_timer: the master drives the controls,
// and the timer (slave) returns its registered status.
interface countdown_timer_if #(
  parameter int unsigned CNT_W = 8
) ();
  logic             start;
  logic             pause;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] count;
  logic             running;
  logic             done;
  logic             expired;

  modport master (
    output start, pause, load, load_val,
    input  count, running, done, expired
  );

  modport slave (
    input  start, pause, load, load_val,
    output count, running, done, expired
  );
endinterface

// File: rtl/countdown_timer.sv
// Prescaled seconds countdown timer with pause/resume and load.
// Defining TIMER_AUTORELOAD_EN reloads the count on expiry instead of stopping in DONE.
module countdown_timer #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned INIT     = 60
) (
  input  logic               clk,
  input  logic               rst,
  countdown_timer_if.slave   bus
);

  localparam int unsigned      PS_W     = $clog2(TICK_DIV);
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT);
`ifdef TIMER_AUTORELOAD_EN
  localparam bit AUTO_RELOAD = 1'b1;
`else
  localparam bit AUTO_RELOAD = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] count_q, count_n;
  logic [CNT_W-1:0] reload_q, reload_n;
  logic [PS_W-1:0]  ps_q, ps_n;
  logic             running_q, done_q, expired_q, expired_n;

  // State and datapath registers; status flags follow the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count_q   <= CNT_INIT;
      reload_q  <= CNT_INIT;
      ps_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state     <= state_n;
      count_q   <= count_n;
      reload_q  <= reload_n;
      ps_q      <= ps_n;
      running_q <= (state_n == RUN);
      done_q    <= (state_n == DONE);
      expired_q <= expired_n;
    end
  end

  // Next-state and datapath; load outranks start, start outranks pause
  always_comb begin
    state_n   = state;
    count_n   = count_q;
    reload_n  = reload_q;
    ps_n      = ps_q;
    expired_n = 1'b0;

    if (bus.load) begin
      state_n  = IDLE;
      count_n  = bus.load_val;
      reload_n = bus.load_val;
      ps_n     = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (count_q != '0) begin
              state_n = RUN;
            end else begin
              state_n   = DONE;
              expired_n = 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.pause && !bus.start) begin
            state_n = PAUSED;
          end else if (ps_q == PS_LAST) begin
            ps_n = '0;
            if (count_q == CNT_W'(1)) begin
              expired_n = 1'b1;
              if (AUTO_RELOAD && (reload_q != '0)) begin
                count_n = reload_q;
              end else begin
                count_n = '0;
                state_n = DONE;
              end
            end else if (count_q != '0) begin
              count_n = count_q - CNT_W'(1);
            end
          end else begin
            ps_n = ps_q + PS_W'(1);
          end
        end
        PAUSED: begin
          if (bus.start) begin
            state_n = RUN;
          end
        end
        DONE: begin
          count_n = '0;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  assign bus.count   = count_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;
  assign bus.expired = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: a remaining-cycles reference model predicts
// every cycle's status, and an independent monitor compares it against the DUT.
module tb_countdown_timer;

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned INIT     = 3;
  localparam int          TD       = 4;
`ifdef TIMER_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  countdown_timer_if #(.CNT_W(CNT_W)) bus ();

  countdown_timer #(
    .CNT_W   (CNT_W),
    .TICK_DIV(TICK_DIV),
    .INIT    (INIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef enum int {M_IDLE, M_RUN, M_PAUSED, M_DONE} mode_t;

  typedef struct {
    logic [CNT_W-1:0] count;
    logic             running;
    logic             done;
    logic             expired;
  } exp_t;

  exp_t  sb_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model: time left is tracked in raw clock cycles, the visible count
  // is the number of whole-or-partial seconds still remaining.
  mode_t m_mode   = M_IDLE;
  int    m_cnt    = INIT;
  int    m_rem    = 0;
  int    m_reload = INIT;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic drive(input logic r, input logic s, input logic p, input logic l, input int lv);
    exp_t e;
    bit   ex;
    int   shown;
    @(negedge clk);
    rst          = r;
    bus.start    = s;
    bus.pause    = p;
    bus.load     = l;
    bus.load_val = CNT_W'(lv);
    ex = 1'b0;
    if (r) begin
      m_mode = M_IDLE; m_cnt = INIT; m_reload = INIT;
    end else if (l) begin
      m_mode = M_IDLE; m_cnt = lv; m_reload = lv;
    end else begin
      case (m_mode)
        M_IDLE: if (s) begin
          if (m_cnt > 0) begin m_mode = M_RUN; m_rem = m_cnt * TD; end
          else begin m_mode = M_DONE; ex = 1'b1; end
        end
        M_RUN: begin
          if (p && !s) m_mode = M_PAUSED;
          else begin
            m_rem--;
            if (m_rem == 0) begin
              ex = 1'b1;
              if (AUTO && m_reload > 0) m_rem = m_reload * TD;
              else m_mode = M_DONE;
            end
          end
        end
        M_PAUSED: if (s) m_mode = M_RUN;
        default: ;
      endcase
    end
    case (m_mode)
      M_IDLE:  shown = m_cnt;
      M_DONE:  shown = 0;
      default: shown = (m_rem + TD - 1) / TD;
    endcase
    e.count   = CNT_W'(shown);
    e.running = (m_mode == M_RUN);
    e.done    = (m_mode == M_DONE);
    e.expired = ex;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  // Monitor: the status registers update every cycle, so one expectation per edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("count",   32'(bus.count), 32'(e.count));
        chk("running", 32'(bus.running), 32'(e.running));
        chk("done",    32'(bus.done), 32'(e.done));
        chk("expired", 32'(bus.expired), 32'(e.expired));
      end
    end
  end

  initial begin
    bus.start    = 1'b0;
    bus.pause    = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;

    drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 9);

    // Basic countdown from INIT into a long DONE hold, start/pause ignored there
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle(32);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 0);
    idle(2);

    // Pause mid-second, then resume with the prescaler preserved
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle(2);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle(14);

    // Zero load then start, and load coincident with start
    drive(1'b0, 1'b0, 1'b0, 1'b1, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle(3);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 5);
    idle(2);

    // Reset mid-run and reset while in DONE
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle(20);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle(6);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle(14);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0);

    // Short reload value: repeating expiry with auto-reload, single expiry without
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle(40);

    // Full-scale count down to zero without underflow
    drive(1'b0, 1'b0, 1'b0, 1'b1, 255);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle(1030);

    // Randomized control traffic with short loads so expiries are frequent
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(199) == 0), ($urandom_range(7) == 0),
            ($urandom_range(9) == 0), ($urandom_range(29) == 0),
            int'($urandom_range(6)));
    end
    idle(3);

    @(posedge clk);
    #2;
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
